// File: rtl/pipe_trace_buffer_if.sv
// Bundle of trace-buffer control, pipeline snapshot and read-back signals.
// The recorder is the slave side and the debug host or bench is the master side.
interface pipe_trace_buffer_if #(
    parameter int STAGES = 5,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int LANE_W = STAGES * DATA_W;

    logic              arm;
    logic [1:0]        mode;
    logic [PTR_W:0]    post_cnt;
    logic              trig_en;
    logic [DATA_W-1:0] trig_pc;
    logic              stop;
    logic              hold;
    logic [LANE_W-1:0] stage_pc;
    logic [LANE_W-1:0] stage_ir;
    logic [STAGES-1:0] stage_valid;
    // Read handshake: rd_en is a request that is honoured only in DONE with
    // count>0; each honoured request yields exactly one rd_valid pulse on the
    // following cycle. There is no back-pressure, and rd_* hold between pops.
    logic              rd_en;
    logic              rd_valid;
    logic [LANE_W-1:0] rd_pc;
    logic [LANE_W-1:0] rd_ir;
    logic [STAGES-1:0] rd_stage_vld;
    logic [PTR_W:0]    count;
    logic [1:0]        state;
    logic              triggered;
    logic              overflow;

    modport master (
        output arm, mode, post_cnt, trig_en, trig_pc, stop, hold,
               stage_pc, stage_ir, stage_valid, rd_en,
        input  rd_valid, rd_pc, rd_ir, rd_stage_vld, count, state,
               triggered, overflow
    );

    modport slave (
        input  arm, mode, post_cnt, trig_en, trig_pc, stop, hold,
               stage_pc, stage_ir, stage_valid, rd_en,
        output rd_valid, rd_pc, rd_ir, rd_stage_vld, count, state,
               triggered, overflow
    );
endinterface

// File: rtl/pipe_trace_buffer.sv
// Pipeline trace recorder: snapshots per-stage PC/IR/valid into a circular RAM
// under trigger control, then drains the entries oldest-first via the pop handshake.
module pipe_trace_buffer #(
    parameter int STAGES = 5,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input logic                clk_i,
    input logic                reset_ni,
    pipe_trace_buffer_if.slave bus
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LANE_W  = STAGES * DATA_W;
    localparam int ENTRY_W = STAGES + 2 * LANE_W;

    localparam logic [PTR_W:0]   FULL_C  = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    localparam logic [1:0] MODE_WRAP = 2'd1;
    localparam logic [1:0] MODE_POST = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CAPT = 2'd1,
        S_POST = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e            state_q;
    logic [1:0]        mode_q;
    logic [PTR_W:0]    post_cnt_q;
    logic [PTR_W:0]    post_left_q;
    logic [PTR_W:0]    count_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic              triggered_q;
    logic              overflow_q;
    logic              rd_valid_q;
    logic [LANE_W-1:0] rd_pc_q;
    logic [LANE_W-1:0] rd_ir_q;
    logic [STAGES-1:0] rd_vld_q;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [ENTRY_W-1:0] wr_entry;
    logic               capture;
    logic               hit;
    logic               pop;
    logic               full;
    logic               wrap_like;

    // arm takes priority over everything, so it also suppresses capture and pop.
    assign capture   = (state_q == S_CAPT || state_q == S_POST) && !bus.hold && !bus.arm;
    assign hit       = capture && (state_q == S_CAPT) && bus.trig_en && bus.stage_valid[0]
                       && (bus.stage_pc[DATA_W-1:0] == bus.trig_pc);
    assign pop       = !bus.arm && (state_q == S_DONE) && bus.rd_en && (count_q != '0);
    assign full      = (count_q == FULL_C);
    assign wrap_like = (mode_q == MODE_WRAP) || (mode_q == MODE_POST);
    assign wr_entry  = {bus.stage_valid, bus.stage_ir, bus.stage_pc};

    always_ff @(posedge clk_i) begin
        if (capture) begin
            mem[wr_ptr_q] <= wr_entry;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rd_pc_q  <= '0;
            rd_ir_q  <= '0;
            rd_vld_q <= '0;
        end else if (pop) begin
            {rd_vld_q, rd_ir_q, rd_pc_q} <= mem[rd_ptr_q];
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= S_IDLE;
            mode_q      <= 2'd0;
            post_cnt_q  <= '0;
            post_left_q <= '0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            triggered_q <= 1'b0;
            overflow_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else if (bus.arm) begin
            state_q     <= S_CAPT;
            mode_q      <= bus.mode;
            post_cnt_q  <= bus.post_cnt;
            post_left_q <= '0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            triggered_q <= 1'b0;
            overflow_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else begin
            rd_valid_q <= pop;
            if (capture) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
                if (!full) begin
                    count_q <= count_q + CNT_ONE;
                end else if (wrap_like) begin
                    // Full ring: the oldest entry is overwritten, so the read side moves on.
                    rd_ptr_q   <= rd_ptr_q + PTR_ONE;
                    overflow_q <= 1'b1;
                end
            end
            if (hit) begin
                triggered_q <= 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
                count_q  <= count_q - CNT_ONE;
            end
            case (state_q)
                S_CAPT: begin
                    case (mode_q)
                        MODE_WRAP: begin
                            if (hit || bus.stop) state_q <= S_DONE;
                        end
                        MODE_POST: begin
                            if (bus.stop) begin
                                state_q <= S_DONE;
                            end else if (hit) begin
                                if (post_cnt_q == '0) begin
                                    state_q <= S_DONE;
                                end else begin
                                    state_q     <= S_POST;
                                    post_left_q <= post_cnt_q;
                                end
                            end
                        end
                        default: begin
                            // FILL (and the reserved encoding) ends on the write that fills the RAM.
                            if (capture && (count_q == FULL_C - CNT_ONE)) state_q <= S_DONE;
                        end
                    endcase
                end
                S_POST: begin
                    if (bus.stop) begin
                        state_q <= S_DONE;
                    end else if (capture) begin
                        post_left_q <= post_left_q - CNT_ONE;
                        if (post_left_q == CNT_ONE) state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (pop && (count_q == CNT_ONE)) state_q <= S_IDLE;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.rd_valid     = rd_valid_q;
    assign bus.rd_pc        = rd_pc_q;
    assign bus.rd_ir        = rd_ir_q;
    assign bus.rd_stage_vld = rd_vld_q;
    assign bus.count        = count_q;
    assign bus.state        = state_q;
    assign bus.triggered    = triggered_q;
    assign bus.overflow     = overflow_q;
endmodule
